repeat_range_scan: RTL and testbench

Sequential range scanner that sums and counts every integer in [lo, hi] whose decimal representation is a digit group repeated two or more times. It is the parametrised successor of the fixed two-group checker: the width and digit capacity are generic, and a runtime mode selects exactly two groups or any group count ≥ 2. It sits between the input-range parser and the final accumulator, and processes one range per start handshake.

---
 rtl/repeat_range_scan.sv | 162 ++++++++++++++++
 tb/tb_repeat_range_scan.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/repeat_range_scan.sv
// Scans [lo, hi] one number per cycle, summing and counting numbers whose decimal
// form is one digit group repeated (exactly twice in mode 0, two or more times in mode 1).
module repeat_range_scan #(
    parameter int DATA_WIDTH      = 40,
    parameter int LONG_DATA_WIDTH = 64,
    parameter int MAX_DIGS        = 13
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [DATA_WIDTH-1:0]      lo_in,
    input  logic [DATA_WIDTH-1:0]      hi_in,
    input  logic                       mode_in,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [LONG_DATA_WIDTH-1:0] sum_out,
    output logic [DATA_WIDTH-1:0]      count_out
);

    localparam int DW = $clog2(MAX_DIGS + 1);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CONV, SCAN, DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   n;
    logic [DATA_WIDTH-1:0]   hi_r;
    logic                    mode_r;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [4*MAX_DIGS-1:0]   bcd;
    logic [CW-1:0]           cnt;
    logic [DW-1:0]           d;

    logic [4*MAX_DIGS-1:0]   bcd_dd;
    logic [DW-1:0]           d_dd;
    logic [4*MAX_DIGS-1:0]   bcd_inc;
    logic [DW-1:0]           d_inc;
    logic                    match;

    // Double-dabble step: the carry out of each adjusted digit feeds the next digit's LSB.
    always_comb begin
        logic [3:0] dig;
        logic [3:0] adj;
        logic       cin;
        bcd_dd = '0;
        d_dd   = '0;
        cin    = shreg[DATA_WIDTH-1];
        for (int unsigned i = 0; i < MAX_DIGS; i++) begin
            dig = bcd[4*i +: 4];
            adj = (dig >= 4'd5) ? dig + 4'd3 : dig;
            bcd_dd[4*i +: 4] = {adj[2:0], cin};
            cin = adj[3];
        end
        for (int unsigned i = 0; i < MAX_DIGS; i++) begin
            if (bcd_dd[4*i +: 4] != 4'd0) d_dd = DW'(i + 1);
        end
    end

    always_comb begin
        logic [3:0] dig;
        logic       carry;
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGS; i++) begin
            dig = bcd[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        d_inc = d;
        for (int unsigned i = 0; i < MAX_DIGS; i++) begin
            if (DW'(i) == d && bcd_inc[4*i +: 4] != 4'd0) d_inc = d + DW'(1);
        end
    end

    // Digits at or above d are zero, so only positions below d take part in the compare.
    always_comb begin
        logic ok;
        match = 1'b0;
        for (int unsigned l = 1; l <= MAX_DIGS / 2; l++) begin
            ok = (DW'(l) < d) && ((d % DW'(l)) == '0) && (mode_r || DW'(2 * l) == d);
            for (int unsigned i = 0; i + l < MAX_DIGS; i++) begin
                if (DW'(i + l) < d && bcd[4*i +: 4] != bcd[4*(i+l) +: 4]) ok = 1'b0;
            end
            match = match | ok;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            start_ready  <= 1'b0;
            result_valid <= 1'b0;
            sum_out      <= '0;
            count_out    <= '0;
            n            <= '0;
            hi_r         <= '0;
            mode_r       <= 1'b0;
            shreg        <= '0;
            bcd          <= '0;
            cnt          <= '0;
            d            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    start_ready  <= 1'b1;
                    result_valid <= 1'b0;
                    if (start_valid && start_ready) begin
                        start_ready <= 1'b0;
                        n           <= lo_in;
                        hi_r        <= hi_in;
                        mode_r      <= mode_in;
                        shreg       <= lo_in;
                        bcd         <= '0;
                        d           <= '0;
                        cnt         <= '0;
                        sum_out     <= '0;
                        count_out   <= '0;
                        state       <= (lo_in > hi_in) ? DONE : CONV;
                    end
                end
                CONV: begin
                    bcd   <= bcd_dd;
                    d     <= d_dd;
                    shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DATA_WIDTH - 1)) state <= SCAN;
                end
                SCAN: begin
                    if (match) begin
                        sum_out   <= sum_out + LONG_DATA_WIDTH'(n);
                        count_out <= count_out + DATA_WIDTH'(1);
                    end
                    if (n == hi_r) begin
                        state <= DONE;
                    end else begin
                        n   <= n + DATA_WIDTH'(1);
                        bcd <= bcd_inc;
                        d   <= d_inc;
                    end
                end
                DONE: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        result_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_repeat_range_scan.sv
// Bench for repeat_range_scan: directed plan cases plus randomized ranges around
// repeated-group numbers, checked against a decimal-string reference model.
module tb_repeat_range_scan;

    localparam int DWID = 40;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [39:0] lo_in;
    logic [39:0] hi_in;
    logic        mode_in;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] sum_out;
    logic [39:0] count_out;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    repeat_range_scan #(.DATA_WIDTH(40), .LONG_DATA_WIDTH(64), .MAX_DIGS(13)) dut (
        .clock(clock), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .lo_in(lo_in), .hi_in(hi_in), .mode_in(mode_in),
        .result_valid(result_valid), .result_ready(result_ready),
        .sum_out(sum_out), .count_out(count_out)
    );

    always #5 clock = ~clock;

    function automatic bit is_rep(input longint unsigned v, input bit mode);
        int unsigned dg[20];
        int unsigned nd = 0;
        bit ok;
        bit any = 1'b0;
        while (v > 0) begin
            dg[nd] = int'(v % 10);
            v = v / 10;
            nd++;
        end
        for (int unsigned l = 1; l < nd; l++) begin
            if (nd % l == 0 && (mode || 2 * l == nd)) begin
                ok = 1'b1;
                for (int unsigned i = 0; i + l < nd; i++)
                    if (dg[i] != dg[i + l]) ok = 1'b0;
                any = any | ok;
            end
        end
        return any;
    endfunction

    task automatic ref_scan(input longint unsigned lo, input longint unsigned hi, input bit mode,
                            output longint unsigned s, output longint unsigned c);
        s = 0;
        c = 0;
        for (longint unsigned v = lo; v <= hi; v++) begin
            if (is_rep(v, mode)) begin
                s = s + v;
                c = c + 1;
            end
        end
    endtask

    function automatic longint unsigned pow10(input int unsigned k);
        longint unsigned p = 1;
        for (int unsigned i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    task automatic stop_on_timeout(input string what);
        n_total++;
        $display("FAIL %s: result_valid never rose within the cycle budget", what);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    // Drives one request and returns the edges from acceptance until result_valid is seen.
    task automatic run_range(input longint unsigned lo, input longint unsigned hi, input bit mode,
                             input bit pulse_mid, output int unsigned cyc);
        bit timed_out = 1'b1;
        @(negedge clock);
        lo_in = lo[39:0];
        hi_in = hi[39:0];
        mode_in = mode;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        lo_in = $urandom;
        hi_in = $urandom;
        mode_in = ~mode;
        cyc = 0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (pulse_mid && cyc == DWID + 2) begin
                lo_in = 40'd11;
                hi_in = 40'd22;
                start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            if (result_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        start_valid = 1'b0;
        if (timed_out) stop_on_timeout("run_range");
    endtask

    task automatic handshake;
        result_ready = 1'b1;
        @(posedge clock);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        lo_in = '0;
        hi_in = '0;
        mode_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_total++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", result_valid); else n_pass++;
        n_total++; if (start_ready !== 1'b0) $display("FAIL reset_ready: got %0b expected 0", start_ready); else n_pass++;
        n_total++; if (sum_out !== 64'd0) $display("FAIL reset_sum: got %0d expected 0", sum_out); else n_pass++;
        n_total++; if (count_out !== 40'd0) $display("FAIL reset_count: got %0d expected 0", count_out); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_total++; if (start_ready !== 1'b1) $display("FAIL ready_after_release: got %0b expected 1", start_ready); else n_pass++;
    endtask

    task automatic test_directed;
        longint unsigned tl[9] = '{11, 95, 95, 998, 998, 222220, 1, 1, 0};
        longint unsigned th[9] = '{22, 115, 115, 1012, 1012, 222224, 9, 9, 12};
        bit              tm[9] = '{0, 0, 1, 0, 1, 1, 0, 1, 1};
        longint unsigned tc[9] = '{2, 1, 2, 1, 2, 1, 0, 0, 1};
        longint unsigned ts[9] = '{33, 99, 210, 1010, 2009, 222222, 0, 0, 11};
        int unsigned cyc;
        for (int i = 0; i < 9; i++) begin
            run_range(tl[i], th[i], tm[i], 1'b0, cyc);
            n_total++; if (cyc !== DWID + int'(th[i] - tl[i]) + 2)
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, DWID + int'(th[i] - tl[i]) + 2); else n_pass++;
            n_total++; if (count_out !== tc[i][39:0])
                $display("FAIL dir%0d_count: got %0d expected %0d", i, count_out, tc[i]); else n_pass++;
            n_total++; if (sum_out !== ts[i])
                $display("FAIL dir%0d_sum: got %0d expected %0d", i, sum_out, ts[i]); else n_pass++;
            handshake();
            n_total++; if (result_valid !== 1'b0 || start_ready !== 1'b1)
                $display("FAIL dir%0d_return_idle: got valid=%0b ready=%0b expected valid=0 ready=1", i, result_valid, start_ready); else n_pass++;
        end
    endtask

    task automatic test_empty_stall;
        int unsigned cyc;
        run_range(500, 400, 1'b0, 1'b0, cyc);
        n_total++; if (cyc !== 1) $display("FAIL empty_latency: got %0d expected 1", cyc); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_total++; if (result_valid !== 1'b1 || start_ready !== 1'b0 || sum_out !== 64'd0 || count_out !== 40'd0)
                $display("FAIL stall%0d: got valid=%0b ready=%0b sum=%0d count=%0d expected 1 0 0 0",
                         k, result_valid, start_ready, sum_out, count_out); else n_pass++;
            @(posedge clock);
            #1;
        end
        handshake();
        n_total++; if (result_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL empty_return_idle: got valid=%0b ready=%0b expected 0 1", result_valid, start_ready); else n_pass++;
    endtask

    task automatic test_abort_restart;
        int unsigned cyc;
        @(negedge clock);
        lo_in = 40'd1188511880;
        hi_in = 40'd1188511890;
        mode_in = 1'b0;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        repeat (DWID + 7) @(posedge clock);
        #1;
        n_total++; if (sum_out !== 64'd1188511885)
            $display("FAIL midscan_sum: got %0d expected 1188511885", sum_out); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (sum_out !== 64'd0 || count_out !== 40'd0 || result_valid !== 1'b0 || start_ready !== 1'b0)
            $display("FAIL abort_outputs: got sum=%0d count=%0d valid=%0b ready=%0b expected all 0",
                     sum_out, count_out, result_valid, start_ready); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_range(1188511880, 1188511890, 1'b0, 1'b1, cyc);
        n_total++; if (cyc !== DWID + 12) $display("FAIL restart_latency: got %0d expected %0d", cyc, DWID + 12); else n_pass++;
        n_total++; if (count_out !== 40'd1) $display("FAIL restart_count: got %0d expected 1", count_out); else n_pass++;
        n_total++; if (sum_out !== 64'd1188511885) $display("FAIL restart_sum: got %0d expected 1188511885", sum_out); else n_pass++;
        handshake();
    endtask

    task automatic test_random;
        longint unsigned lo, hi, num, grp, es, ec, off;
        int unsigned glen, reps;
        bit mode;
        int unsigned cyc;
        for (int it = 0; it < 9; it++) begin
            if (it == 8) begin
                lo = (64'd1 << 40) - 20;
                hi = (64'd1 << 40) - 1;
            end else begin
                glen = $urandom_range(1, 4);
                reps = $urandom_range(2, 12 / glen);
                grp = longint'($urandom_range(int'(pow10(glen - 1)), int'(pow10(glen) - 1)));
                if (grp == 0) grp = 1;
                num = 0;
                for (int unsigned r = 0; r < reps; r++) num = num * pow10(glen) + grp;
                off = longint'($urandom_range(0, 30));
                if (off > num) off = num;
                lo = num - off;
                hi = lo + longint'($urandom_range(0, 60));
            end
            mode = 1'($urandom_range(0, 1));
            ref_scan(lo, hi, mode, es, ec);
            run_range(lo, hi, mode, 1'b0, cyc);
            n_total++; if (cyc !== DWID + int'(hi - lo) + 2)
                $display("FAIL rnd%0d_latency: got %0d expected %0d", it, cyc, DWID + int'(hi - lo) + 2); else n_pass++;
            n_total++; if (count_out !== ec[39:0])
                $display("FAIL rnd%0d_count lo=%0d hi=%0d mode=%0b: got %0d expected %0d", it, lo, hi, mode, count_out, ec); else n_pass++;
            n_total++; if (sum_out !== es)
                $display("FAIL rnd%0d_sum lo=%0d hi=%0d mode=%0b: got %0d expected %0d", it, lo, hi, mode, sum_out, es); else n_pass++;
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_empty_stall();
        test_abort_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
